display_scan: RTL and testbench
===============================

# display_scan

Downstream stage of the menu text generator. Takes the 28-bit four-digit segment word from the menu or from the game logic and drives a multiplexed 4-digit 7-segment display.
- Selects the source from the game state code `presente`.
- Latches the selected word only at frame boundaries, so a scroll step never tears mid-frame.
- Time-multiplexes the anodes with a guard interval and 3-bit PWM brightness.

## Interface
Parameters:
- `REFRESH_DIV`, 18000 — clk cycles per digit slot; `REFRESH_DIV - GUARD` must be a multiple of 8, minimum 10.
- `GUARD`, 2000 — blanking cycles at the start of each slot (anti-ghosting), ≥ 1.
- `SEG_ACT_LOW`, 1 — 1: `seg` active-low.
- `AN_ACT_LOW`, 1 — 1: `an` active-low.

Ports:
- `clk` in 1 — system clock; the only clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `presente` in 3 — game state code (OFF=0, WLCM=1, CH=2, GAME=3, WL=4, PA=5; 6, 7 unused).
- `display_menu` in 28 — menu word; digit k = bits [7k+6:7k], segment bit 0 = a, active-high.
- `display_game` in 28 — game word, same format.
- `brillo` in 3 — brightness, 0 = dimmest, 7 = full.
- `seg` out 7 — segment drive for the current digit.
- `an` out 4 — anode enables; `an[k]` ↔ digit k, and digit 0 is the leftmost.
- `frame_tick` out 1 — one-cycle pulse on each frame-word latch.

## Operation
- Source select:
  - WLCM or CH → `display_menu`.
  - GAME, WL or PA → `display_game`.
  - Codes 6 and 7 → all-zero word.
- FSM has two states, BLANK and SCAN.
  - Reset state is BLANK.
  - BLANK: counters held at 0; `an` all inactive; `seg` all inactive.
  - BLANK → SCAN: on the first clk edge with `presente != OFF`. That edge latches the selected word into `frame_q` and pulses `frame_tick`.
  - SCAN → BLANK: on any edge with `presente == OFF`, regardless of slot position. Counters clear.
- Counters, active only in SCAN:
  - `slot_cnt` runs 0..REFRESH_DIV-1.
  - `digit` (2 bits) increments when `slot_cnt` wraps, 3→0 wrap.
- Frame latch: on the cycle with `digit==3 && slot_cnt==REFRESH_DIV-1`:
  - `frame_q` ← currently selected source word; `frame_tick`=1.
  - Source changes between latches are not visible.
- Output generation:
  - `seg` = `frame_q[7·digit+6 : 7·digit]`, inverted if SEG_ACT_LOW.
  - `an[digit]` is active iff `GUARD ≤ slot_cnt < GUARD + ((brillo+1)·(REFRESH_DIV−GUARD))>>3`.
  - All other anodes are inactive.
  - `brillo` is sampled every cycle, with no latching.
- Arithmetic:
  - `slot_cnt` width is `$clog2(REFRESH_DIV)`.
  - The on-window product is computed at width `$clog2(REFRESH_DIV)+3`, so it cannot overflow.
- Never more than one anode active in any cycle.

## Timing
- `seg`, `an` and `frame_tick` are registered; each reflects counter and state values with 1 clk latency.
- Reset values: `an`=all inactive (4'hF at default params), `seg`=all inactive (7'h7F), `frame_tick`=0, `frame_q`=0, `slot_cnt`=0, `digit`=0.
- Reset asserted mid-frame: outputs go inactive asynchronously.
- First visible anode after entering SCAN: digit 0, `GUARD+1` cycles after the transition edge.
- Frame period is `4·REFRESH_DIV` cycles; one latch per frame.
- Simultaneous events:
  - OFF arriving on the frame-latch cycle: BLANK wins; no latch, no `frame_tick`.
  - `presente` changing on the latch cycle: the new source is latched.

## Structure
- Shared package `heroe_pkg` holds the game-state constants (OFF..PA) and the 7-segment letter constants (A..Z); `menu` and the game logic use it too.
- Sub-module `scan_timer` holds `slot_cnt`, `digit` and the frame-wrap strobe, with an enable/clear input.
- The top level holds source select, `frame_q`, the FSM, the PWM compare and the output registers.

## Test plan
All scenarios run with REFRESH_DIV=18, GUARD=2.
- Reset:
  - Hold `rst_n`=0 with `presente`=CH → `an`=4'hF, `seg`=7'h7F, `frame_tick`=0.
  - Release `rst_n` with `presente`=OFF → outputs stay inactive indefinitely.
- Scan order:
  - `presente`=WLCM, `display_menu`={A,L,O,H} (H in [6:0]), `brillo`=7.
  - → `an` = 4'b1110, 4'b1101, 4'b1011, 4'b0111 in turn, each active for 16 cycles within an 18-cycle slot.
  - → `seg` = ~H, ~O, ~L, ~A; `frame_tick` every 72 cycles.
- PWM: `brillo`=0 → each anode active for exactly 2 cycles (slot_cnt 2..3); `brillo`=3 → 8 cycles.
- Tear-free latch:
  - Change `display_menu` while digit 1 is showing → the remaining digits of that frame keep the old word.
  - The new word appears from digit 0 of the next frame.
- Source switch: `presente` CH→GAME mid-frame → `display_game` is shown from the next frame. Codes 6/7 → `seg` inactive while the anodes keep scanning.
- Mid-frame OFF and reset:
  - `presente`→OFF during digit 2 → `an`=4'hF one cycle later.
  - Returning to WLCM → restarts at digit 0 with an immediate `frame_tick`.
  - `rst_n` pulse mid-slot → outputs inactive in the same cycle (asynchronous).

Source files
------------

// File: rtl/heroe_pkg.sv
// Shared constants for the heroe game: state codes, 7-segment
// letter glyphs (bit 0 = segment a, active-high) and word types.
package heroe_pkg;

  typedef logic [2:0]      estado_t;
  typedef logic [6:0]      seg7_t;
  typedef logic [3:0][6:0] word_t;

  localparam estado_t OFF  = 3'd0;
  localparam estado_t WLCM = 3'd1;
  localparam estado_t CH   = 3'd2;
  localparam estado_t GAME = 3'd3;
  localparam estado_t WL   = 3'd4;
  localparam estado_t PA   = 3'd5;

  localparam seg7_t A = 7'h77;
  localparam seg7_t B = 7'h7C;
  localparam seg7_t C = 7'h39;
  localparam seg7_t D = 7'h5E;
  localparam seg7_t E = 7'h79;
  localparam seg7_t F = 7'h71;
  localparam seg7_t G = 7'h3D;
  localparam seg7_t H = 7'h76;
  localparam seg7_t I = 7'h06;
  localparam seg7_t J = 7'h1E;
  localparam seg7_t K = 7'h75;
  localparam seg7_t L = 7'h38;
  localparam seg7_t M = 7'h37;
  localparam seg7_t N = 7'h54;
  localparam seg7_t O = 7'h3F;
  localparam seg7_t P = 7'h73;
  localparam seg7_t Q = 7'h67;
  localparam seg7_t R = 7'h50;
  localparam seg7_t S = 7'h6D;
  localparam seg7_t T = 7'h78;
  localparam seg7_t U = 7'h3E;
  localparam seg7_t V = 7'h1C;
  localparam seg7_t W = 7'h2A;
  localparam seg7_t X = 7'h49;
  localparam seg7_t Y = 7'h6E;
  localparam seg7_t Z = 7'h5B;

endpackage

// File: rtl/scan_timer.sv
// Slot and digit counters for the display multiplexer, with the
// combinational end-of-frame strobe.
module scan_timer #(
  parameter int REFRESH_DIV = 18000,
  parameter int CW          = $clog2(REFRESH_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] slot_cnt,
  output logic [1:0]    digit,
  output logic          wrap
);

  logic last;

  assign last = slot_cnt == CW'(REFRESH_DIV - 1);
  assign wrap = en && last && (digit == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      digit    <= '0;
    end else if (clr) begin
      slot_cnt <= '0;
      digit    <= '0;
    end else if (en) begin
      if (last) begin
        slot_cnt <= '0;
        digit    <= digit + 2'd1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scan.sv
// Multiplexed 4-digit 7-segment driver: source select, frame-aligned
// word latch, guarded PWM anode window and registered outputs.
module display_scan
  import heroe_pkg::*;
#(
  parameter int REFRESH_DIV = 18000,
  parameter int GUARD       = 2000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  presente,
  input  logic [27:0] display_menu,
  input  logic [27:0] display_game,
  input  logic [2:0]  brillo,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SCAN  = 1'b1;

  localparam logic [CW+2:0] SPAN    = (CW+3)'(REFRESH_DIV - GUARD);
  localparam logic [CW+2:0] GUARD_W = (CW+3)'(GUARD);
  localparam logic [CW+2:0] ONE     = (CW+3)'(1);

  localparam logic [6:0] SEG_POL = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_POL  = AN_ACT_LOW ? 4'hF : 4'h0;

  logic [0:0]    state_q;
  logic [CW-1:0] slot_cnt;
  logic [1:0]    digit;
  logic          wrap;
  logic          run;
  logic          load;
  logic          on;
  word_t         sel;
  word_t         frame_q;
  logic [CW+2:0] prod;
  logic [CW+2:0] hi;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;

  assign run = (state_q == ST_SCAN) && (presente != OFF);

  scan_timer #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (run),
    .clr     (!run),
    .slot_cnt(slot_cnt),
    .digit   (digit),
    .wrap    (wrap)
  );

  always_comb begin
    sel = '0;
    unique case (1'b1)
      (presente == WLCM) || (presente == CH):
        sel = display_menu;
      (presente == GAME) || (presente == WL) || (presente == PA):
        sel = display_game;
      default:
        sel = '0;
    endcase
  end

  // entering SCAN and every frame end both capture the live source
  assign load = ((state_q == ST_BLANK) && (presente != OFF))
              || (run && wrap);

  assign prod = ({{CW{1'b0}}, brillo} + ONE) * SPAN;
  assign hi   = (prod >> 3) + GUARD_W;

  assign on = run
           && (slot_cnt >= CW'(GUARD))
           && ({3'b000, slot_cnt} < hi);

  assign seg_nxt = run ? frame_q[digit] : 7'h00;
  assign an_nxt  = on ? (4'b0001 << digit) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BLANK;
      frame_q    <= '0;
      frame_tick <= 1'b0;
      seg        <= SEG_POL;
      an         <= AN_POL;
    end else begin
      state_q    <= (presente != OFF) ? ST_SCAN : ST_BLANK;
      if (load)
        frame_q  <= sel;
      frame_tick <= load;
      seg        <= seg_nxt ^ SEG_POL;
      an         <= an_nxt ^ AN_POL;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: elapsed-time reference model of the
// scan, checked every cycle under directed and random stimulus.
module tb_display_scan;
  import heroe_pkg::*;

  localparam int T_RD    = 18;
  localparam int T_GUARD = 2;
  localparam int T_FRAME = 4 * T_RD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  presente;
  logic [27:0] display_menu;
  logic [27:0] display_game;
  logic [2:0]  brillo;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_scan = 1'b0;
  int          m_k = 0;
  logic [27:0] m_word = '0;

  always #5 clk = ~clk;

  display_scan #(
    .REFRESH_DIV(T_RD),
    .GUARD      (T_GUARD),
    .SEG_ACT_LOW(1'b1),
    .AN_ACT_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .presente    (presente),
    .display_menu(display_menu),
    .display_game(display_game),
    .brillo      (brillo),
    .seg         (seg),
    .an          (an),
    .frame_tick  (frame_tick)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [27:0] src_word();
    case (presente)
      3'd1, 3'd2:       return display_menu;
      3'd3, 3'd4, 3'd5: return display_game;
      default:          return 28'h0;
    endcase
  endfunction

  // position within the frame the outputs currently describe
  function automatic int cur_digit();
    return ((m_k - 1) % T_FRAME) / T_RD;
  endfunction

  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_tick;
    int pos, d, s, on_len;
    e_an   = 4'hF;
    e_seg  = 7'h7F;
    e_tick = 1'b0;
    if (presente == 3'd0) begin
      m_scan = 1'b0;
    end else if (!m_scan) begin
      m_scan = 1'b1;
      m_k    = 0;
      m_word = src_word();
      e_tick = 1'b1;
    end else begin
      m_k++;
      pos    = (m_k - 1) % T_FRAME;
      d      = pos / T_RD;
      s      = pos % T_RD;
      on_len = ((int'(brillo) + 1) * (T_RD - T_GUARD)) / 8;
      if (s >= T_GUARD && s < T_GUARD + on_len)
        e_an = 4'hF ^ (4'b0001 << d);
      e_seg = ~m_word[7*d +: 7];
      if (m_k % T_FRAME == 0) begin
        e_tick = 1'b1;
        m_word = src_word();
      end
    end
    @(posedge clk);
    #1;
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("frame_tick", frame_tick, e_tick);
    chk("one_anode", $countones(~an) <= 1, 1);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_to_digit(input int d);
    int guard_cnt;
    guard_cnt = 0;
    while (!(m_scan && m_k > 0 && cur_digit() == d && ((m_k - 1) % T_RD) == 3)
           && guard_cnt < 4 * T_FRAME) begin
      step();
      guard_cnt++;
    end
    chk("reach_digit", guard_cnt < 4 * T_FRAME, 1);
  endtask

  initial begin
    rst_n        = 1'b0;
    presente     = CH;
    brillo       = 3'd7;
    display_menu = '0;
    display_game = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_tick", frame_tick, 0);

    presente = OFF;
    #2 rst_n = 1'b1;
    run(20);

    display_menu = {A, L, O, H};
    presente     = WLCM;
    run(2 * T_FRAME + 10);

    brillo = 3'd0;
    run(T_FRAME + 5);
    brillo = 3'd3;
    run(T_FRAME + 5);
    brillo = 3'd7;

    run_to_digit(1);
    display_menu = {H, O, L, A};
    run(2 * T_FRAME);

    presente     = CH;
    display_game = {P, L, A, Y};
    run(20);
    presente = GAME;
    run(2 * T_FRAME);

    presente = 3'd6;
    run(T_FRAME + 10);
    presente = 3'd7;
    run(40);
    presente = WLCM;
    run(T_FRAME);

    run_to_digit(2);
    presente = OFF;
    step();
    chk("off_an", an, 4'hF);
    run(5);
    presente = WLCM;
    step();
    chk("restart_tick", frame_tick, 1);
    run(T_FRAME + 20);

    run_to_digit(1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_an", an, 4'hF);
    chk("async_seg", seg, 7'h7F);
    chk("async_tick", frame_tick, 0);
    m_scan = 1'b0;
    #1 rst_n = 1'b1;
    run(T_FRAME + 10);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3)
        presente = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 10)
        brillo = 3'($urandom);
      if ($urandom_range(0, 99) < 5)
        display_menu = 28'($urandom);
      if ($urandom_range(0, 99) < 5)
        display_game = 28'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
